// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: shared widths, ecall/mret encodings and sequencer state encoding
package trap_ctrl_pkg;
    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam logic [31:0] ECALL_ENC = 32'h0000_0073;
    localparam logic [31:0] MRET_ENC = 32'h3020_0073;
    localparam logic [6:0] SYSTEM_OP = 7'b111_0011;
    typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, FLUSH} state_t;
endpackage

// File: rtl/trap_decode.sv
// trap_decode: combinational ecall/mret classifier, shared with the CSR-side decode
module trap_decode
    import trap_ctrl_pkg::*;
(
    input  logic [ILEN-1:0] instr,
    output logic            is_ecall,
    output logic            is_mret
);
    logic is_system;
    always_comb begin
        is_system = instr[6:0] == SYSTEM_OP;
        is_ecall = is_system & (instr == ECALL_ENC);
        is_mret = is_system & (instr == MRET_ENC);
    end
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: commit-stage ecall/mret sequencer (drain, CSR trap pulse, redirect, flush).
// Define TRAP_CTRL_PERF_EN to add the trap_cnt_o performance counter.
module trap_ctrl #(
    parameter int XLEN = 64,
    parameter int ILEN = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [ILEN-1:0] instr_i,
    input  logic            lsu_busy_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    output logic [XLEN-1:0] csr_pc_o,
    output logic [ILEN-1:0] csr_instr_o,
    output logic            trap_o,
    output logic            ret_o,
    output logic            stall_o,
    output logic            flush_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o
`ifdef TRAP_CTRL_PERF_EN
    ,
    output logic [XLEN-1:0] trap_cnt_o
`endif
);
    import trap_ctrl_pkg::*;

    state_t          state, state_nxt;
    logic            is_ecall, is_mret, is_event, accept, kind_mret;
    logic [XLEN-1:0] pc_q, mepc_q, target_q;
    logic [ILEN-1:0] instr_q;
    logic [3:0]      cnt;

    trap_decode u_decode (
        .instr    (instr_i),
        .is_ecall (is_ecall),
        .is_mret  (is_mret)
    );

    always_comb begin
        is_event = is_ecall | is_mret;
        accept = (state == IDLE) & valid_i & is_event;
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? (lsu_busy_i ? DRAIN : COMMIT) : IDLE;
            DRAIN:   state_nxt = lsu_busy_i ? DRAIN : COMMIT;
            COMMIT:  state_nxt = FLUSH;
            FLUSH:   state_nxt = (cnt == 4'd1) ? IDLE : FLUSH;
            default: state_nxt = IDLE;
        endcase
        stall_o = (state != IDLE) | (valid_i & is_event);
        trap_o = state == COMMIT;
        ret_o = trap_o & kind_mret;
        csr_pc_o = pc_q;
        csr_instr_o = trap_o ? instr_q : instr_i;
        flush_o = state == FLUSH;
        redirect_valid_o = flush_o & (cnt == 4'(FLUSH_CYCLES));
        redirect_pc_o = target_q & ~XLEN'(3);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            kind_mret <= 1'b0;
            pc_q <= '0;
            instr_q <= '0;
            mepc_q <= '0;
            target_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                pc_q <= pc_i;
                instr_q <= instr_i;
                kind_mret <= is_mret;
            end
            // CSR rewrites mepc on the COMMIT edge, so the return target is captured on entry
            if (state_nxt == COMMIT)
                mepc_q <= mepc_i;
            if (state == COMMIT) begin
                target_q <= kind_mret ? mepc_q : mtvec_i;
                cnt <= 4'(FLUSH_CYCLES);
            end else if (state == FLUSH) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

`ifdef TRAP_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            trap_cnt_o <= '0;
        else if (trap_o)
            trap_cnt_o <= trap_cnt_o + XLEN'(1);
    end
`endif
endmodule
